// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: imem request/response channel plus decode-side redirect and output word.
// FETCH_MISALIGN_EN adds the misalign_f flag to the bundle.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        branch_d;
   logic [31:0] branch_next_addr_d;
   logic        stall_f;
   logic [31:0] instruction_f;
   logic [31:0] pc_f;
   logic        mem_valid_f;
`ifdef FETCH_MISALIGN_EN
   logic        misalign_f;

   modport master (
      output imem_req, imem_addr, instruction_f, pc_f, mem_valid_f, misalign_f,
      input  imem_gnt, imem_rvalid, imem_rdata, branch_d, branch_next_addr_d, stall_f
   );
   modport slave (
      input  imem_req, imem_addr, instruction_f, pc_f, mem_valid_f, misalign_f,
      output imem_gnt, imem_rvalid, imem_rdata, branch_d, branch_next_addr_d, stall_f
   );
`else
   modport master (
      output imem_req, imem_addr, instruction_f, pc_f, mem_valid_f,
      input  imem_gnt, imem_rvalid, imem_rdata, branch_d, branch_next_addr_d, stall_f
   );
   modport slave (
      input  imem_req, imem_addr, instruction_f, pc_f, mem_valid_f,
      output imem_gnt, imem_rvalid, imem_rdata, branch_d, branch_next_addr_d, stall_f
   );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order imem reads, buffers {pc,instr} for decode.
// Optional FETCH_MISALIGN_EN flags misaligned redirect targets and halts fetch until the next redirect.
module fetch_unit #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [PTR_W-1:0] ptr_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic [31:0] pc_q, pc_d;
   logic [31:0] resp_pc_q, resp_pc_d;
   cnt_t        outst_q, outst_d;
   cnt_t        drop_q, drop_d;
   cnt_t        count_q, count_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   ptr_t        wr_ptr_q, wr_ptr_d;
   entry_t      fifo_q [DEPTH];

   logic [CNT_W:0] in_use;
   logic           fetch_blocked;
   logic           grant;
   logic           mem_valid;
   logic           push;
   logic           pop;
   entry_t         head;

`ifdef FETCH_MISALIGN_EN
   logic misalign_q, misalign_d;
   logic inhibit_q, inhibit_d;
   logic target_misaligned;

   assign target_misaligned = (bus.branch_next_addr_d[1:0] != 2'b00);
   assign fetch_blocked     = inhibit_q;
   assign bus.misalign_f    = misalign_q;
`else
   assign fetch_blocked = 1'b0;
`endif

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // Credit check on registered counts: words in flight plus words buffered never exceed DEPTH.
   assign in_use       = {1'b0, outst_q} + {1'b0, count_q};
   assign bus.imem_req = !rst && !bus.branch_d && !fetch_blocked && (in_use < (CNT_W+1)'(DEPTH));
   assign bus.imem_addr = pc_q;
   assign grant        = bus.imem_req && bus.imem_gnt;

   assign mem_valid = (count_q != '0) && !bus.branch_d;
   assign pop       = mem_valid && !bus.stall_f;
   assign push      = bus.imem_rvalid && !bus.branch_d && (drop_q == '0);
   assign head      = fifo_q[rd_ptr_q];

   assign bus.mem_valid_f   = mem_valid;
   assign bus.instruction_f = mem_valid ? head.instr : NOP;
   assign bus.pc_f          = mem_valid ? head.pc : 32'h0;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path infers a latch.
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      outst_d   = outst_q + cnt_t'(grant) - cnt_t'(bus.imem_rvalid);
      drop_d    = drop_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
`ifdef FETCH_MISALIGN_EN
      misalign_d = misalign_q;
      inhibit_d  = inhibit_q;
`endif
      if (bus.branch_d) begin
         // Everything already granted is wrong-path; the word returning right now is dropped here.
         pc_d      = bus.branch_next_addr_d & ~32'h3;
         resp_pc_d = bus.branch_next_addr_d & ~32'h3;
         drop_d    = outst_q - cnt_t'(bus.imem_rvalid);
         count_d   = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
`ifdef FETCH_MISALIGN_EN
         misalign_d = misalign_q | target_misaligned;
         inhibit_d  = target_misaligned;
`endif
      end else begin
         if (grant) pc_d = pc_q + 32'd4;
         if (bus.imem_rvalid && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         outst_q   <= '0;
         drop_q    <= '0;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
`ifdef FETCH_MISALIGN_EN
         misalign_q <= 1'b0;
         inhibit_q  <= 1'b0;
`endif
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         outst_q   <= outst_d;
         drop_q    <= drop_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
`ifdef FETCH_MISALIGN_EN
         misalign_q <= misalign_d;
         inhibit_q  <= inhibit_d;
`endif
      end
   end

   // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: bus.imem_rdata};
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc,instr}; a monitor checks every pop.
// The imem model returns (addr ^ 32'h5A5A_0000) after K cycles and grants only while budget > 0.
module tb_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   fetch_unit_if fif ();

   fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (fif)
   );

   always #5 clk = ~clk;

   exp_t  exp_q[$];
   pend_t pend_q[$];
   int    n_pass  = 0;
   int    n_total = 0;
   int    budget  = 0;
   int    k_lat   = 1;
   int    cyc     = 0;
   int    last_due = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
   endtask

   task automatic exp_push(input logic [31:0] pc, input logic [31:0] instr);
      exp_q.push_back('{pc: pc, instr: instr});
   endtask

   // imem model: responds first (in order), then grants the request presented this cycle.
   initial begin
      fif.imem_gnt    = 1'b0;
      fif.imem_rvalid = 1'b0;
      fif.imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         cyc++;
         #1;
         if (rst) begin
            pend_q.delete();
            fif.imem_gnt    = 1'b0;
            fif.imem_rvalid = 1'b0;
            last_due        = 0;
         end else begin
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
               fif.imem_rvalid = 1'b1;
               fif.imem_rdata  = pend_q[0].addr ^ 32'h5A5A_0000;
               void'(pend_q.pop_front());
            end else begin
               fif.imem_rvalid = 1'b0;
               fif.imem_rdata  = 32'h0;
            end
            fif.imem_gnt = (budget > 0);
            #0;
            if (fif.imem_req && fif.imem_gnt) begin
               last_due = (cyc + k_lat > last_due) ? cyc + k_lat : last_due + 1;
               pend_q.push_back('{addr: fif.imem_addr, due: last_due});
               budget--;
            end
         end
      end
   end

   // Monitor: every cycle that will pop a word compares it against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && fif.mem_valid_f && !fif.stall_f) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word_pc", fif.pc_f, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", fif.pc_f, e.pc);
               check("pop_instr", fif.instruction_f, e.instr);
            end
         end
      end
   end

   task automatic do_reset(input int kk, input int bud);
      @(negedge clk);
      rst = 1'b1;
      fif.branch_d = 1'b0;
      fif.branch_next_addr_d = 32'h0;
      fif.stall_f = 1'b0;
      budget = 0;
      repeat (2) @(negedge clk);
      #2;
      check("rst_imem_req", {31'h0, fif.imem_req}, 32'h0);
      check("rst_mem_valid", {31'h0, fif.mem_valid_f}, 32'h0);
      check("rst_instruction", fif.instruction_f, NOP);
      check("rst_pc_f", fif.pc_f, 32'h0);
`ifdef FETCH_MISALIGN_EN
      check("rst_misalign", {31'h0, fif.misalign_f}, 32'h0);
`endif
      k_lat  = kk;
      budget = bud;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_budget_spent();
      int g = 0;
      while (budget != 0 && g < 20) begin
         @(negedge clk);
         g++;
      end
      check("grant_timeout_budget", budget, 0);
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 300) begin
         @(negedge clk);
         g++;
      end
      check("drain_left", exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      fif.branch_d = 1'b0;
      fif.branch_next_addr_d = 32'h0;
      fif.stall_f = 1'b0;

      // 1: streaming, first valid word in the third cycle after reset.
      for (int i = 0; i < 6; i++) begin
         logic [31:0] a;
         a = 32'(4 * i);
         exp_push(a, a ^ 32'h5A5A_0000);
      end
      do_reset(1, 6);
      #2 check("t1_valid_c1", {31'h0, fif.mem_valid_f}, 32'h0);
      @(negedge clk); #2 check("t1_valid_c2", {31'h0, fif.mem_valid_f}, 32'h0);
      @(negedge clk); #2 check("t1_valid_c3", {31'h0, fif.mem_valid_f}, 32'h1);
      wait_drain();

      // 2: stall holds the head word and throttles requests, then resumes losslessly.
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         a = 32'(4 * i);
         exp_push(a, a ^ 32'h5A5A_0000);
      end
      do_reset(1, 8);
      begin
         int g = 0;
         while (!fif.mem_valid_f && g < 20) begin
            @(negedge clk);
            g++;
         end
      end
      fif.stall_f = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #2;
         check("t2_stall_pc", fif.pc_f, 32'h0);
         check("t2_stall_instr", fif.instruction_f, 32'h5A5A_0000);
      end
      check("t2_stall_req", {31'h0, fif.imem_req}, 32'h0);
      @(negedge clk);
      fif.stall_f = 1'b0;
      wait_drain();

      // 3: k=3, two requests in flight, redirect to 0x100 drops both.
      do_reset(3, 2);
      wait_budget_spent();
      fif.branch_d = 1'b1;
      fif.branch_next_addr_d = 32'h0000_0100;
      budget = 4;
      exp_push(32'h0000_0100, 32'h5A5A_0100);
      exp_push(32'h0000_0104, 32'h5A5A_0104);
      exp_push(32'h0000_0108, 32'h5A5A_0108);
      exp_push(32'h0000_010C, 32'h5A5A_010C);
      #2 check("t3_req_in_redirect", {31'h0, fif.imem_req}, 32'h0);
      check("t3_valid_in_redirect", {31'h0, fif.mem_valid_f}, 32'h0);
      @(negedge clk);
      fif.branch_d = 1'b0;
      wait_drain();

      // 4a: k=2, redirect coincides with rvalid while two are outstanding; the later word is dropped too.
      do_reset(2, 2);
      wait_budget_spent();
      fif.branch_d = 1'b1;
      fif.branch_next_addr_d = 32'h0000_0200;
      budget = 3;
      exp_push(32'h0000_0200, 32'h5A5A_0200);
      exp_push(32'h0000_0204, 32'h5A5A_0204);
      exp_push(32'h0000_0208, 32'h5A5A_0208);
      @(negedge clk);
      fif.branch_d = 1'b0;
      wait_drain();

      // 4b: k=3, back-to-back redirects 0x200 then 0x300; the last target wins.
      do_reset(3, 2);
      wait_budget_spent();
      fif.branch_d = 1'b1;
      fif.branch_next_addr_d = 32'h0000_0200;
      budget = 3;
      @(negedge clk);
      fif.branch_next_addr_d = 32'h0000_0300;
      exp_push(32'h0000_0300, 32'h5A5A_0300);
      exp_push(32'h0000_0304, 32'h5A5A_0304);
      exp_push(32'h0000_0308, 32'h5A5A_0308);
      @(negedge clk);
      fif.branch_d = 1'b0;
      wait_drain();

      // 5: grant withheld -> request held at a stable address, output drains to NOP; then PC wrap.
      exp_push(32'h0000_0000, 32'h5A5A_0000);
      exp_push(32'h0000_0004, 32'h5A5A_0004);
      do_reset(1, 2);
      wait_drain();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2;
         check("t5_req_held", {31'h0, fif.imem_req}, 32'h1);
         check("t5_addr_held", fif.imem_addr, 32'h0000_0008);
         check("t5_valid_low", {31'h0, fif.mem_valid_f}, 32'h0);
         check("t5_instr_nop", fif.instruction_f, NOP);
         check("t5_pc_zero", fif.pc_f, 32'h0);
      end
      @(negedge clk);
      fif.branch_d = 1'b1;
      fif.branch_next_addr_d = 32'hFFFF_FFFC;
      budget = 2;
      exp_push(32'hFFFF_FFFC, 32'hA5A5_FFFC);
      exp_push(32'h0000_0000, 32'h5A5A_0000);
      @(negedge clk);
      fif.branch_d = 1'b0;
      #2 check("t5_wrap_addr_first", fif.imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      #2 check("t5_wrap_addr_next", fif.imem_addr, 32'h0000_0000);
      wait_drain();

`ifdef FETCH_MISALIGN_EN
      // 6: misaligned redirect flags and halts fetch; an aligned redirect resumes it.
      do_reset(1, 0);
      fif.branch_d = 1'b1;
      fif.branch_next_addr_d = 32'h0000_0102;
      #2 check("t6_misalign_before", {31'h0, fif.misalign_f}, 32'h0);
      @(negedge clk);
      fif.branch_d = 1'b0;
      budget = 4;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #2;
         check("t6_misalign_set", {31'h0, fif.misalign_f}, 32'h1);
         check("t6_req_inhibited", {31'h0, fif.imem_req}, 32'h0);
      end
      @(negedge clk);
      fif.branch_d = 1'b1;
      fif.branch_next_addr_d = 32'h0000_0200;
      exp_push(32'h0000_0200, 32'h5A5A_0200);
      exp_push(32'h0000_0204, 32'h5A5A_0204);
      exp_push(32'h0000_0208, 32'h5A5A_0208);
      exp_push(32'h0000_020C, 32'h5A5A_020C);
      @(negedge clk);
      fif.branch_d = 1'b0;
      wait_drain();
      #2 check("t6_misalign_sticky", {31'h0, fif.misalign_f}, 32'h1);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
